ex_wb_stage: RTL and testbench

EX_WB_STAGE -- requirements
Module: ex_wb_stage

---
 rtl/ex_wb_stage_pkg.sv | 29 ++
 rtl/ex_wb_hold_reg.sv | 21 ++
 rtl/ex_wb_stage.sv | 153 +++++++++++++++
 tb/tb_ex_wb_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_stage_pkg.sv
// Shared definitions for the EX/WB stage: ALU select codes, write-back FSM
// encoding and the default high-word destination register.
package ex_wb_stage_pkg;

  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_SUB = 3'd1,
    ALU_OP_AND = 3'd2,
    ALU_OP_OR  = 3'd3,
    ALU_OP_MUL = 3'd4,
    ALU_OP_DIV = 3'd5,
    ALU_OP_XOR = 3'd6,
    ALU_OP_SHL = 3'd7
  } alu_op_t;

  typedef logic [1:0] wb_state_t;

  localparam wb_state_t ST_IDLE = 2'd0;
  localparam wb_state_t ST_LO   = 2'd1;
  localparam wb_state_t ST_HI   = 2'd2;

  localparam int HI_REG_DEFAULT = 15;

  // Only MUL and DIV produce a meaningful high word that needs its own beat.
  function automatic logic is_wide_op(input logic [2:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
  endfunction

endpackage

// File: rtl/ex_wb_hold_reg.sv
// Capture register for one ALU result: loads on enable, cleared asynchronously.
module ex_wb_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Result capture with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB stage: turns one ALU result into one (narrow) or two (wide) register
// write beats. Define EX_WB_FWD_EN to add the fwd_* forwarding outputs.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int HI_REG = HI_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_yhigh,
  input  logic [DATA_W-1:0] in_ylow,
  input  logic              in_n,
  input  logic              in_z,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_n,
  output logic              flag_z,
  output logic              busy
`ifdef EX_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int HW = 5 + ADDR_W + 2 * DATA_W;
  localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(HI_REG);

  wb_state_t         state_r;
  wb_state_t         state_nxt_s;
  logic [HW-1:0]     hold_d_s;
  logic [HW-1:0]     hold_q_s;
  logic [2:0]        held_op_s;
  logic              held_n_s;
  logic              held_z_s;
  logic [ADDR_W-1:0] held_dest_s;
  logic [DATA_W-1:0] held_yhigh_s;
  logic [DATA_W-1:0] held_ylow_s;
  logic              held_wide_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              lo_done_s;
  logic              pending_r;
  logic              flag_n_r;
  logic              flag_z_r;
  logic [ADDR_W-1:0] wb_addr_r;
  logic [DATA_W-1:0] wb_data_r;

  assign hold_d_s = {in_op, in_n, in_z, in_dest, in_yhigh, in_ylow};
  assign {held_op_s, held_n_s, held_z_s, held_dest_s, held_yhigh_s, held_ylow_s} = hold_q_s;
  assign held_wide_s = is_wide_op(held_op_s);
  assign accept_s    = in_valid & in_ready_s;
  assign lo_done_s   = (state_r == ST_LO) & wb_ready;

  ex_wb_hold_reg #(
    .W (HW)
  ) u_hold (
    .clk (clk),
    .rst (rst),
    .en  (accept_s),
    .d   (hold_d_s),
    .q   (hold_q_s)
  );

  // Next state and acceptance; a new result may enter on the final beat of the current one
  always_comb begin
    in_ready_s  = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          state_nxt_s = ST_LO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LO: begin
        if (!wb_ready) begin
          state_nxt_s = ST_LO;
        end else if (held_wide_s) begin
          state_nxt_s = ST_HI;
        end else begin
          in_ready_s  = 1'b1;
          state_nxt_s = in_valid ? ST_LO : ST_IDLE;
        end
      end
      ST_HI: begin
        in_ready_s = wb_ready;
        if (wb_ready) begin
          state_nxt_s = in_valid ? ST_LO : ST_IDLE;
        end else begin
          state_nxt_s = ST_HI;
        end
      end
      default: begin
        in_ready_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, flags and registered write-back beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b0;
      flag_n_r  <= 1'b0;
      flag_z_r  <= 1'b0;
      wb_addr_r <= {ADDR_W{1'b0}};
      wb_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= (state_nxt_s != ST_IDLE);
      if (lo_done_s) begin
        flag_n_r <= held_n_s;
        flag_z_r <= held_z_s;
      end
      // The HI beat targets HI_REG even when dest aliases it, so it lands last
      if (accept_s) begin
        wb_addr_r <= in_dest;
        wb_data_r <= in_ylow;
      end else if (lo_done_s && held_wide_s) begin
        wb_addr_r <= HI_ADDR;
        wb_data_r <= held_yhigh_s;
      end
    end
  end

  assign in_ready = in_ready_s;
  assign wb_valid = pending_r;
  assign busy     = pending_r;
  assign wb_addr  = wb_addr_r;
  assign wb_data  = wb_data_r;
  assign flag_n   = flag_n_r;
  assign flag_z   = flag_z_r;

`ifdef EX_WB_FWD_EN
  assign fwd_valid = pending_r;
  assign fwd_addr  = wb_addr_r;
  assign fwd_data  = wb_data_r;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Scoreboard bench for ex_wb_stage: directed scenarios plus random traffic and
// backpressure, checked against a beat-list reference model.
module tb_ex_wb_stage;
  import ex_wb_stage_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'd0;
  logic [AW-1:0] in_dest = '0;
  logic [DW-1:0] in_yhigh = '0;
  logic [DW-1:0] in_ylow = '0;
  logic          in_n = 1'b0;
  logic          in_z = 1'b0;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          flag_n;
  logic          flag_z;
  logic          busy;

  ex_wb_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_dest  (in_dest),
    .in_yhigh (in_yhigh),
    .in_ylow  (in_ylow),
    .in_n     (in_n),
    .in_z     (in_z),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // One expected register write; lo marks the beat that sets the flags,
  // last marks the final beat of its result.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lo;
    logic          last;
    logic          n;
    logic          z;
  } beat_t;

  beat_t sbq[$];
  beat_t mb;
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  logic  exp_n = 1'b0;
  logic  exp_z = 1'b0;
  bit    mon_en = 1'b0;
  bit    rand_bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: each accepted result becomes its list of writes
  task automatic push_result(input logic [2:0] op, input logic [AW-1:0] d,
                             input logic [DW-1:0] yh, input logic [DW-1:0] yl,
                             input logic n, input logic z);
    bit wide;
    beat_t b;
    wide = (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
    b.addr = d; b.data = yl; b.lo = 1'b1; b.last = !wide; b.n = n; b.z = z;
    sbq.push_back(b);
    if (wide) begin
      b.addr = 4'd15; b.data = yh; b.lo = 1'b0; b.last = 1'b1; b.n = 1'b0; b.z = 1'b0;
      sbq.push_back(b);
    end
  endtask

  // Monitor: compares the presented beat, handshake and flags against the model
  always @(negedge clk) begin
    cyc++;
    if (mon_en && !rst) begin
      check("wb_valid", {31'd0, wb_valid}, {31'd0, sbq.size() != 0});
      check("busy", {31'd0, busy}, {31'd0, sbq.size() != 0});
      check("flag_n", {31'd0, flag_n}, {31'd0, exp_n});
      check("flag_z", {31'd0, flag_z}, {31'd0, exp_z});
      if (sbq.size() != 0) begin
        check("wb_addr", {28'd0, wb_addr}, {28'd0, sbq[0].addr});
        check("wb_data", {16'd0, wb_data}, {16'd0, sbq[0].data});
        check("in_ready", {31'd0, in_ready}, {31'd0, wb_ready && sbq[0].last});
        if (wb_ready) begin
          mb = sbq.pop_front();
          if (mb.lo) begin
            exp_n = mb.n;
            exp_z = mb.z;
          end
        end
      end else begin
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [AW-1:0] d,
                      input logic [DW-1:0] yh, input logic [DW-1:0] yl,
                      input logic n, input logic z);
    bit acc;
    int t;
    in_valid = 1'b1; in_op = op; in_dest = d; in_yhigh = yh; in_ylow = yl; in_n = n; in_z = z;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      if (rand_bp) wb_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) push_result(op, d, yh, yl, n, z);
      t++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_op = 3'($urandom); in_dest = 4'($urandom);
      in_yhigh = 16'($urandom); in_ylow = 16'($urandom);
      if (rand_bp) wb_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    while (sbq.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  initial begin
    int start;
    #12;
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flag_n", {31'd0, flag_n}, 32'd0);
    check("rst_flag_z", {31'd0, flag_z}, 32'd0);
    check("rst_wb_addr", {28'd0, wb_addr}, 32'd0);
    check("rst_wb_data", {16'd0, wb_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    mon_en = 1'b1;

    // Add, multiply, zero-flag sequence
    send(ALU_OP_ADD, 4'd3, 16'h0000, 16'd15, 1'b0, 1'b0);
    drain();
    send(ALU_OP_MUL, 4'd2, 16'h000F, 16'h4A11, 1'b0, 1'b0);
    drain();
    send(ALU_OP_ADD, 4'd5, 16'h0000, 16'h0000, 1'b0, 1'b1);
    drain();
    send(ALU_OP_MUL, 4'd6, 16'h0001, 16'h0002, 1'b0, 1'b0);
    drain();

    // Backpressure for three cycles during LO
    send(ALU_OP_SUB, 4'd7, 16'h0000, 16'h1234, 1'b1, 1'b0);
    wb_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    drain();

    // Streaming four narrow ops must take exactly four cycles
    start = cyc;
    send(ALU_OP_ADD, 4'd1, 16'h0, 16'h0011, 1'b0, 1'b0);
    send(ALU_OP_SUB, 4'd2, 16'h0, 16'h0022, 1'b1, 1'b0);
    send(ALU_OP_AND, 4'd3, 16'h0, 16'h0000, 1'b0, 1'b1);
    send(ALU_OP_OR,  4'd4, 16'h0, 16'h0044, 1'b0, 1'b0);
    check("stream_cycles", 32'(cyc - start), 32'd4);
    drain();

    // Wide op writing HI_REG itself: both beats, high word last
    send(ALU_OP_DIV, 4'd15, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0);
    drain();

    // Reset while the HI beat of a MUL is pending
    send(ALU_OP_MUL, 4'd4, 16'h00FF, 16'h8000, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("hi_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("hi_rst_busy", {31'd0, busy}, 32'd0);
    check("hi_rst_flag_n", {31'd0, flag_n}, 32'd0);
    check("hi_rst_flag_z", {31'd0, flag_z}, 32'd0);
    sbq.delete();
    exp_n = 1'b0;
    exp_z = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // Random traffic with random backpressure
    rand_bp = 1'b1;
    repeat (200) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      send(3'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom));
    end
    rand_bp = 1'b0;
    drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
